// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-RAM arbiter: FSM states, access owner and write-mask helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Reads must never strobe byte lanes, whatever d_be happens to hold.
  function automatic logic [3:0] wr_mask(input logic we, input logic [3:0] be);
    return we ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant select for the RAM arbiter: data beats fetch until fetch has lost
// STARVE_LIMIT consecutive contended grants, then fetch is forced through.
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_grant_en,
  output logic o_grant_d
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;

  assign o_grant_d = i_d_req && !(i_if_req && (r_starve_cnt == LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_grant_en) begin
      // Only a data grant that leaves fetch waiting counts toward starvation.
      if (o_grant_d && i_if_req) begin
        if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 1-cycle-latency RAM between instruction fetch and data ports.
// Each access takes IDLE -> ACCESS (mem_en) -> RESP (ack) -> IDLE, three cycles minimum.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [3:0]        i_d_be,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_ack,
  output logic [31:0]       o_d_rdata,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_busy
);

  state_t              r_state;
  owner_t              r_owner;
  logic                r_mem_en;
  logic [3:0]          r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_if_ack;
  logic                r_d_ack;
  logic                r_d_rd;
  logic                w_grant_en;
  logic                w_grant_d;

  assign w_grant_en = (r_state == ST_IDLE) && (i_if_req || i_d_req);

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .i_if_req  (i_if_req),
    .i_d_req   (i_d_req),
    .i_grant_en(w_grant_en),
    .o_grant_d (w_grant_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 4'b0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_rd      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          if (w_grant_en) begin
            r_state  <= ST_ACCESS;
            r_mem_en <= 1'b1;
            if (w_grant_d) begin
              r_owner     <= OWN_D;
              r_mem_we    <= wr_mask(i_d_we, i_d_be);
              r_mem_addr  <= i_d_addr;
              r_mem_wdata <= i_d_wdata;
              r_d_rd      <= !i_d_we;
            end else begin
              r_owner     <= OWN_IF;
              r_mem_we    <= 4'b0000;
              r_mem_addr  <= i_if_addr;
              r_mem_wdata <= '0;
              r_d_rd      <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_RESP;
          r_mem_en <= 1'b0;
          r_mem_we <= 4'b0000;
          r_if_ack <= (r_owner == OWN_IF);
          r_d_ack  <= (r_owner == OWN_D);
        end
        ST_RESP: begin
          r_state  <= ST_IDLE;
          r_owner  <= OWN_NONE;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM data lands during RESP, so the read path is steered by the registered acks.
  assign o_if_rdata  = r_if_ack ? i_mem_rdata : 32'h0;
  assign o_d_rdata   = (r_d_ack && r_d_rd) ? i_mem_rdata : 32'h0;
  assign o_if_ack    = r_if_ack;
  assign o_d_ack     = r_d_ack;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = 4'h0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_ack   (if_ack),
    .o_if_rdata (if_rdata),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_be     (d_be),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .o_d_ack    (d_ack),
    .o_d_rdata  (d_rdata),
    .o_mem_en   (mem_en),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_busy     (busy)
  );

  // Single-port RAM with one cycle read latency, read-before-write.
  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: an access granted in cycle g strobes the RAM in g+1, acks in g+2, frees the arbiter at g+3.
  int          next_idle = 0;
  int          g_cyc = -10;
  int          m_owner = 0;     // 1 = fetch, 2 = data
  int          m_starve = 0;
  logic [AW-1:0] e_addr;
  logic [3:0]  e_we;
  logic [31:0] e_wdata;
  logic [31:0] e_rdata;
  bit          e_rd;
  int          n_dack = 0;
  int          n_iack = 0;
  bit          auto_rand = 0;
  bit          hold_d = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit pick_d;
    bit en_exp;
    bit ack_exp;
    if (rst) begin
      g_cyc     = -10;
      m_starve  = 0;
      next_idle = cyc + 1;
    end else if (cyc >= next_idle && (if_req || d_req)) begin
      pick_d    = d_req && !(if_req && m_starve == SL);
      g_cyc     = cyc;
      next_idle = cyc + 3;
      if (pick_d) begin
        m_owner  = 2;
        m_starve = if_req ? m_starve + 1 : 0;
        e_addr   = d_addr;
        e_we     = d_we ? d_be : 4'h0;
        e_wdata  = d_wdata;
        e_rd     = !d_we;
        e_rdata  = d_we ? 32'h0 : ref_mem[d_addr];
        for (int i = 0; i < 4; i++)
          if (e_we[i]) ref_mem[e_addr][8*i +: 8] = e_wdata[8*i +: 8];
      end else begin
        m_owner  = 1;
        m_starve = 0;
        e_addr   = if_addr;
        e_we     = 4'h0;
        e_wdata  = 32'h0;
        e_rd     = 1'b1;
        e_rdata  = ref_mem[if_addr];
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;

    en_exp  = (cyc == g_cyc + 1);
    ack_exp = (cyc == g_cyc + 2);
    check("mem_en",   32'(mem_en), 32'(en_exp));
    check("busy",     32'(busy),   32'(en_exp || ack_exp));
    check("if_ack",   32'(if_ack), 32'(ack_exp && m_owner == 1));
    check("d_ack",    32'(d_ack),  32'(ack_exp && m_owner == 2));
    check("if_rdata", if_rdata, (ack_exp && m_owner == 1) ? e_rdata : 32'h0);
    check("d_rdata",  d_rdata,  (ack_exp && m_owner == 2 && e_rd) ? e_rdata : 32'h0);
    if (en_exp) begin
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_we",   32'(mem_we),   32'(e_we));
      if (e_we != 4'h0) check("mem_wdata", mem_wdata, e_wdata);
    end else begin
      check("mem_we_idle", 32'(mem_we), 32'h0);
    end

    if (if_ack) n_iack++;
    if (d_ack)  n_dack++;
    if (if_ack) if_req = 1'b0;
    if (d_ack)  d_req  = hold_d;

    if (auto_rand) begin
      // Granted requester's inputs are scrambled to prove the arbiter registered them.
      if (cyc == g_cyc + 1 && $urandom_range(0, 1) == 1) begin
        if (m_owner == 1) if_addr = AW'($urandom);
        else begin
          d_addr  = AW'($urandom);
          d_wdata = $urandom;
          d_be    = 4'($urandom);
        end
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = ($urandom_range(0, 9) == 0) ? AW'((1 << AW) - 1) : AW'($urandom_range(0, 15));
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom);
        d_addr  = AW'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    int t0;
    int dcyc;
    int icyc;

    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end

    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    step();

    // Fetch only.
    ram[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = AW'(5);
    step();
    check("fetch_mem_addr", 32'(mem_addr), 32'd5);
    step();
    check("fetch_ack",   32'(if_ack), 32'd1);
    check("fetch_rdata", if_rdata, 32'hDEADBEEF);
    drain();

    // Byte write then read-back.
    ram[3] = 32'h11223344; ref_mem[3] = 32'h11223344;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = AW'(3); d_wdata = 32'h0000AB00;
    step(); step();
    check("bytewr_ack", 32'(d_ack), 32'd1);
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(3);
    step(); step();
    check("bytewr_rd_ack",   32'(d_ack), 32'd1);
    check("bytewr_rd_rdata", d_rdata, 32'h1122AB44);
    drain();

    // Contention: data first, fetch re-arbitrated right after.
    if_req = 1'b1; if_addr = AW'(8);
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(9);
    t0 = cyc; dcyc = -1; icyc = -1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (d_ack && dcyc < 0)  dcyc = cyc;
      if (if_ack && icyc < 0) icyc = cyc;
    end
    check("contend_d_lat",  32'(dcyc - t0), 32'd2);
    check("contend_if_lat", 32'(icyc - t0), 32'd5);
    drain();

    // Starvation guard, two rounds to show the counter restarts after a fetch grant.
    hold_d = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(2);
    for (int r = 0; r < 2; r++) begin
      if_req = 1'b1; if_addr = AW'(4);
      n_dack = 0; n_iack = 0;
      for (int i = 0; i < 60 && n_iack == 0; i++) step();
      check("starve_if_ack", 32'(n_iack), 32'd1);
      check("starve_d_acks", 32'(n_dack), 32'(SL));
    end
    hold_d = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Reset during the ACCESS cycle of a fetch.
    if_req = 1'b1; if_addr = AW'(5);
    step();
    check("rst_in_access_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_busy",   32'(busy),   32'd0);
    check("rst_mid_mem_en", 32'(mem_en), 32'd0);
    check("rst_mid_if_ack", 32'(if_ack), 32'd0);
    rst = 1'b0;
    t0 = cyc; icyc = -1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (if_ack && icyc < 0) icyc = cyc;
    end
    check("rst_reissue_lat", 32'(icyc - t0), 32'd2);
    drain();

    // Write with no byte enables.
    ram[7] = 32'h55; ref_mem[7] = 32'h55;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = AW'(7); d_wdata = 32'hFFFFFFFF;
    step();
    check("zbe_mem_we", 32'(mem_we), 32'd0);
    step();
    check("zbe_ack", 32'(d_ack), 32'd1);
    drain();
    check("zbe_ram7", ram[7], 32'h55);

    // Random traffic.
    auto_rand = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    auto_rand = 1'b0;
    for (int i = 0; i < 40 && (if_req || d_req || busy); i++) step();
    check("rand_drained", 32'(if_req || d_req || busy), 32'd0);
    for (int i = 0; i < 16; i++) check("rand_ram", ram[i], ref_mem[i]);
    check("rand_ram_top", ram[(1 << AW) - 1], ref_mem[(1 << AW) - 1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
